dmem_responder: RTL and testbench

Data-memory target for the CPU core's dmem interface. It accepts word read and write requests, inserts a programmable number of wait states, and answers with a one-cycle ready pulse. It decodes the address into a local word RAM, a small memory-mapped I/O window (GPIO register, cycle counter, status), and an unmapped region. It sits on the system side of the dmem bus, between the core and board I/O.

---
 rtl/dmem_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory target for the CPU core's dmem bus. It accepts one word read or
// write at a time, stretches it by WAIT_STATES wait cycles, and completes it
// with a single-cycle dmem_ready pulse. Addresses decode to a local word RAM,
// a three-register MMIO window (GPIO, free-running cycle counter, status) or
// an unmapped region that answers with bus_error.
//
// Ports:
//   clk              system clock, all state changes on the rising edge
//   rst_n            asynchronous active-low reset
//   dmem_addr        byte address of the access, bits [1:0] ignored
//   dmem_write_data  data for write accesses
//   dmem_read_en     read request
//   dmem_write_en    write request (wins when both enables are high)
//   dmem_read_data   registered read data, updated when a response starts
//   dmem_ready       one-cycle completion pulse
//   gpio_out         MMIO GPIO output register
//   bus_error        one-cycle pulse alongside dmem_ready on unmapped access
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 1024,
    parameter int                    WAIT_STATES = 2,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [DATA_WIDTH-1:0] dmem_write_data,
    input  logic                  dmem_read_en,
    input  logic                  dmem_write_en,
    output logic [DATA_WIDTH-1:0] dmem_read_data,
    output logic                  dmem_ready,
    output logic [DATA_WIDTH-1:0] gpio_out,
    output logic                  bus_error
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int WORD_W = ADDR_WIDTH - 2;

    // All decode works on word addresses so the ignored byte offset never
    // takes part in a compare.
    localparam logic [WORD_W-1:0] GPIO_WORD = MMIO_BASE[ADDR_WIDTH-1:2];
    localparam logic [WORD_W-1:0] CNT_WORD  = GPIO_WORD + WORD_W'(1);
    localparam logic [WORD_W-1:0] STAT_WORD = GPIO_WORD + WORD_W'(2);
    localparam logic [WORD_W-1:0] RAM_WORDS = WORD_W'(MEM_DEPTH);

    localparam logic [3:0] WS_CFG  = 4'(WAIT_STATES);
    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_wcnt;
    logic [3:0]            w_next_wcnt;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we;

    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_gpio;
    logic [DATA_WIDTH-1:0] r_cycle;
    logic                  r_err_sticky;
    logic                  r_berr_pend;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_req;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_we;
    logic [WORD_W-1:0]     w_word;
    logic [IDX_W-1:0]      w_ram_idx;
    logic                  w_hit_ram;
    logic                  w_hit_gpio;
    logic                  w_hit_cnt;
    logic                  w_hit_stat;
    logic                  w_unmapped;
    logic [DATA_WIDTH-1:0] w_status;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused_byte_offset;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign w_req = dmem_read_en | dmem_write_en;

    // NOTE: every flop below uses non-blocking assignment so all registers
    // update together from the values present before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_wcnt  <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_wcnt  <= w_next_wcnt;
        end
    end

    // NOTE: defaults come first so every path assigns every output of this
    // block, which keeps it purely combinational (no latches).
    always_comb begin
        w_next_state = r_state;
        w_next_wcnt  = r_wcnt;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (WAIT_STATES > 0) begin
                        w_next_state = WAIT;
                        w_next_wcnt  = WS_INIT;
                    end else begin
                        w_next_state = RESP;
                    end
                end
            end
            WAIT: begin
                if (r_wcnt == 4'd0) begin
                    w_next_state = RESP;
                end else begin
                    w_next_wcnt = r_wcnt - 4'd1;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // The edge that enters RESP is the single commit point for both writes
    // and read-data capture. With zero wait states that edge is the request
    // edge itself, so the request fields are taken straight from the bus
    // while in IDLE and from the latched copy otherwise.
    assign w_commit = (w_next_state == RESP) && (r_state != RESP);

    assign w_addr  = (r_state == IDLE) ? dmem_addr       : r_addr;
    assign w_wdata = (r_state == IDLE) ? dmem_write_data : r_wdata;
    assign w_we    = (r_state == IDLE) ? dmem_write_en   : r_we;

    assign w_unused_byte_offset = &{1'b0, w_addr[1:0]};

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_word     = w_addr[ADDR_WIDTH-1:2];
    assign w_ram_idx  = w_word[IDX_W-1:0];
    assign w_hit_ram  = (w_word < RAM_WORDS);
    assign w_hit_gpio = (w_word == GPIO_WORD);
    assign w_hit_cnt  = (w_word == CNT_WORD);
    assign w_hit_stat = (w_word == STAT_WORD);
    assign w_unmapped = !(w_hit_ram || w_hit_gpio || w_hit_cnt || w_hit_stat);

    // Status: bit0 sticky error, bits [4:1] the configured wait states.
    assign w_status = {{(DATA_WIDTH-5){1'b0}}, WS_CFG, r_err_sticky};

    always_comb begin
        w_rdata = '0;
        if (w_hit_ram) begin
            w_rdata = r_mem[w_ram_idx];
        end else if (w_hit_gpio) begin
            w_rdata = r_gpio;
        end else if (w_hit_cnt) begin
            w_rdata = r_cycle;
        end else if (w_hit_stat) begin
            w_rdata = w_status;
        end
    end

    // ------------------------------------------------------------------
    // Request capture, MMIO registers and response data
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_rdata      <= '0;
            r_gpio       <= '0;
            r_cycle      <= '0;
            r_err_sticky <= 1'b0;
            r_berr_pend  <= 1'b0;
        end else begin
            // Counter free-runs and wraps naturally; a read sees the value
            // held just before the commit edge.
            r_cycle <= r_cycle + 1'b1;

            if (r_state == IDLE && w_req) begin
                r_addr  <= dmem_addr;
                r_wdata <= dmem_write_data;
                r_we    <= dmem_write_en;
            end

            if (w_commit) begin
                // A write (including read+write together) returns zero data.
                r_rdata     <= w_we ? '0 : w_rdata;
                r_berr_pend <= w_unmapped;
                if (w_unmapped) begin
                    r_err_sticky <= 1'b1;
                end
                if (w_we && w_hit_gpio) begin
                    r_gpio <= w_wdata;
                end
            end
        end
    end

    // NOTE: the RAM array has no reset; its contents are undefined until
    // written, which lets it map onto block memory. The rst_n term stops a
    // request held during reset from writing on a clock edge.
    always_ff @(posedge clk) begin
        if (rst_n && w_commit && w_we && w_hit_ram) begin
            r_mem[w_ram_idx] <= w_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dmem_ready     = (r_state == RESP);
    assign bus_error      = (r_state == RESP) && r_berr_pend;
    assign dmem_read_data = r_rdata;
    assign gpio_out       = r_gpio;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. One instance runs with two wait states
// and carries most of the checks; a second instance with zero wait states
// covers back-to-back requests with the enable held high.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam logic [31:0] MMIO = 32'hFFFF_0000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    // Two-wait-state instance
    logic [31:0] addr   = '0;
    logic [31:0] wdata  = '0;
    logic        re     = 1'b0;
    logic        we     = 1'b0;
    logic [31:0] rdata;
    logic        rdy;
    logic [31:0] gpio;
    logic        berr;

    // Zero-wait-state instance
    logic [31:0] addr0  = '0;
    logic [31:0] wdata0 = '0;
    logic        re0    = 1'b0;
    logic        we0    = 1'b0;
    logic [31:0] rdata0;
    logic        rdy0;
    logic [31:0] gpio0;
    logic        berr0;

    int          n_tests = 0;
    int          n_fail  = 0;
    longint      tb_cyc  = 0;

    // Values captured at the ready cycle of the last access
    logic [31:0] s_rdata;
    logic [31:0] s_gpio;
    logic        s_berr;
    int          s_lat;
    longint      s_cyc;

    logic [31:0] v1;
    longint      c1;

    dmem_responder #(.WAIT_STATES(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dmem_addr       (addr),
        .dmem_write_data (wdata),
        .dmem_read_en    (re),
        .dmem_write_en   (we),
        .dmem_read_data  (rdata),
        .dmem_ready      (rdy),
        .gpio_out        (gpio),
        .bus_error       (berr)
    );

    dmem_responder #(.WAIT_STATES(0)) dut0 (
        .clk             (clk),
        .rst_n           (rst_n),
        .dmem_addr       (addr0),
        .dmem_write_data (wdata0),
        .dmem_read_en    (re0),
        .dmem_write_en   (we0),
        .dmem_read_data  (rdata0),
        .dmem_ready      (rdy0),
        .gpio_out        (gpio0),
        .bus_error       (berr0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // One access on the two-wait-state instance. Inputs change on the falling
    // edge; the request is sampled on the next rising edge and ready is
    // expected on the third falling edge after it. Enables drop as soon as
    // ready is seen, and the cycle after must show ready low again.
    task automatic dm_access(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic r, input logic w);
        @(negedge clk);
        addr  = a;
        wdata = d;
        re    = r;
        we    = w;
        s_lat = 0;
        s_rdata = '0;
        s_gpio  = '0;
        s_berr  = 1'b0;
        s_cyc   = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (rdy) begin
                s_lat   = n;
                s_rdata = rdata;
                s_gpio  = gpio;
                s_berr  = berr;
                s_cyc   = tb_cyc;
                break;
            end
        end
        re = 1'b0;
        we = 1'b0;
        check({tag, "_latency"}, 32'(s_lat), 32'd3);
        @(negedge clk);
        check({tag, "_pulse_end"}, {31'b0, rdy}, 32'd0);
    endtask

    task automatic ws0_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr0  = a;
        wdata0 = d;
        we0    = 1'b1;
        @(negedge clk);
        check("ws0_wr_ready", {31'b0, rdy0}, 32'd1);
        we0 = 1'b0;
        @(negedge clk);
        check("ws0_wr_pulse_end", {31'b0, rdy0}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready",  {31'b0, rdy},  32'd0);
        check("rst_rdata",  rdata,         32'd0);
        check("rst_gpio",   gpio,          32'd0);
        check("rst_berr",   {31'b0, berr}, 32'd0);
        check("rst_ready0", {31'b0, rdy0}, 32'd0);
        rst_n = 1'b1;

        // Zero wait states: back-to-back reads with read_en held high
        ws0_write(32'h0, 32'h1111_0000);
        ws0_write(32'h4, 32'h2222_0004);
        @(negedge clk);
        addr0 = 32'h0;
        re0   = 1'b1;
        @(negedge clk);
        check("ws0_rd0_ready", {31'b0, rdy0}, 32'd1);
        check("ws0_rd0_data",  rdata0,        32'h1111_0000);
        addr0 = 32'h4;
        @(negedge clk);
        check("ws0_gap_ready", {31'b0, rdy0}, 32'd0);
        @(negedge clk);
        check("ws0_rd1_ready", {31'b0, rdy0}, 32'd1);
        check("ws0_rd1_data",  rdata0,        32'h2222_0004);
        re0 = 1'b0;
        @(negedge clk);
        check("ws0_tail0_ready", {31'b0, rdy0}, 32'd0);
        @(negedge clk);
        check("ws0_tail1_ready", {31'b0, rdy0}, 32'd0);

        // RAM write then read back
        dm_access("wr10", 32'h10, 32'hCAFE_0001, 1'b0, 1'b1);
        check("wr10_berr", {31'b0, s_berr}, 32'd0);
        dm_access("rd10", 32'h10, 32'h0, 1'b1, 1'b0);
        check("rd10_data", s_rdata,         32'hCAFE_0001);
        check("rd10_berr", {31'b0, s_berr}, 32'd0);

        // Both enables: treated as a write, read data forced to zero
        dm_access("both20", 32'h20, 32'h1234_5678, 1'b1, 1'b1);
        check("both20_data", s_rdata, 32'h0);
        dm_access("rd20", 32'h20, 32'h0, 1'b1, 1'b0);
        check("rd20_data", s_rdata, 32'h1234_5678);

        // GPIO write is visible at the ready cycle, and reads back
        dm_access("wrgpio", MMIO, 32'h0000_00A5, 1'b0, 1'b1);
        check("wrgpio_out",  s_gpio,          32'h0000_00A5);
        check("wrgpio_berr", {31'b0, s_berr}, 32'd0);
        dm_access("rdgpio", MMIO, 32'h0, 1'b1, 1'b0);
        check("rdgpio_data", s_rdata, 32'h0000_00A5);

        // Cycle counter: writes ignored, two reads differ by the commit spacing
        dm_access("wrcnt", MMIO + 32'h4, 32'hDEAD_BEEF, 1'b0, 1'b1);
        check("wrcnt_berr", {31'b0, s_berr}, 32'd0);
        dm_access("rdcnt_a", MMIO + 32'h4, 32'h0, 1'b1, 1'b0);
        v1 = s_rdata;
        c1 = s_cyc;
        repeat (5) @(negedge clk);
        dm_access("rdcnt_b", MMIO + 32'h4, 32'h0, 1'b1, 1'b0);
        check("cnt_delta", s_rdata - v1, 32'(s_cyc - c1));

        // Status before any error: only the wait-state field (2 << 1)
        dm_access("stat0", MMIO + 32'h8, 32'h0, 1'b1, 1'b0);
        check("stat0_data", s_rdata, 32'h0000_0004);

        // Unmapped read and write
        dm_access("unmap_rd", 32'h8000_0000, 32'h0, 1'b1, 1'b0);
        check("unmap_rd_data", s_rdata,         32'h0);
        check("unmap_rd_berr", {31'b0, s_berr}, 32'd1);
        dm_access("unmap_wr", MMIO + 32'hC, 32'h0BAD_0BAD, 1'b0, 1'b1);
        check("unmap_wr_berr", {31'b0, s_berr}, 32'd1);
        check("unmap_wr_gpio", s_gpio,          32'h0000_00A5);

        // Sticky error bit now set alongside the wait-state field
        dm_access("stat1", MMIO + 32'h8, 32'h0, 1'b1, 1'b0);
        check("stat1_data", s_rdata,         32'h0000_0005);
        check("stat1_berr", {31'b0, s_berr}, 32'd0);

        // RAM upper boundary: last word mapped, the next one is not
        dm_access("wrlast", 32'hFFC, 32'h55AA_33CC, 1'b0, 1'b1);
        check("wrlast_berr", {31'b0, s_berr}, 32'd0);
        dm_access("rdlast", 32'hFFC, 32'h0, 1'b1, 1'b0);
        check("rdlast_data", s_rdata, 32'h55AA_33CC);
        dm_access("rdpast", 32'h1000, 32'h0, 1'b1, 1'b0);
        check("rdpast_berr", {31'b0, s_berr}, 32'd1);
        check("rdpast_data", s_rdata,         32'h0);
        dm_access("rdlast2", 32'hFFC, 32'h0, 1'b1, 1'b0);

        // Reset during WAIT aborts the write; outputs clear at once
        @(negedge clk);
        addr  = 32'h40;
        wdata = 32'hFFFF_FFFF;
        we    = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'b0, rdy},  32'd0);
        check("abort_gpio",  gpio,          32'd0);
        check("abort_rdata", rdata,         32'd0);
        check("abort_berr",  {31'b0, berr}, 32'd0);
        we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Counter restarted: one idle edge, then request edge, one wait edge,
        // commit edge reading the value held before it (3).
        dm_access("cnt_restart", MMIO + 32'h4, 32'h0, 1'b1, 1'b0);
        check("cnt_restart_val", s_rdata, 32'd3);
        dm_access("stat_after_rst", MMIO + 32'h8, 32'h0, 1'b1, 1'b0);
        check("stat_after_rst_data", s_rdata, 32'h0000_0004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
